// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner selection for three I2C masters sharing one open-drain bus, with a guard gap between owners.
// Optional grant timeout with per-requester masking is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
    parameter int GUARD_CYCLES   = 125,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic       CLK_50,
    input  logic       RESET_N,
    input  logic [2:0] REQ,
    input  logic [2:0] SCL_IN,
    input  logic [2:0] SDAO_IN,
    input  logic       CLR_TIMEOUT,
    output logic [2:0] GNT,
    output logic       BUS_SCL,
    output logic       BUS_SDAO,
    output logic       BUSY,
    output logic       TIMEOUT_FLAG,
    output logic [1:0] TIMEOUT_ID
);

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t      state, state_next;
    logic [31:0] counter, counter_next;
    logic [2:0]  gnt_next;
    logic [2:0]  eligible;
    logic [1:0]  last_owner, last_owner_next;
    logic [1:0]  win_idx;
    logic        owner_req;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [2:0] mask, mask_next;
    logic       flag_next;
    logic [1:0] id_next;

    assign eligible = REQ & ~mask;
`else
    logic unused_cfg;

    assign unused_cfg   = CLR_TIMEOUT ^ (TIMEOUT_CYCLES == 0);
    assign eligible     = REQ;
    assign TIMEOUT_FLAG = 1'b0;
    assign TIMEOUT_ID   = 2'd0;
`endif

    // GNT is one-hot or zero, so masking with it selects the owner's lines only
    assign owner_req = |(REQ & GNT);
    assign BUS_SCL   = &(SCL_IN | ~GNT);
    assign BUS_SDAO  = &(SDAO_IN | ~GNT);

    always_comb begin
        win_idx = 2'd0;
        case (last_owner)
            2'd0: begin
                if (eligible[1])      win_idx = 2'd1;
                else if (eligible[2]) win_idx = 2'd2;
                else                  win_idx = 2'd0;
            end
            2'd1: begin
                if (eligible[2])      win_idx = 2'd2;
                else if (eligible[0]) win_idx = 2'd0;
                else                  win_idx = 2'd1;
            end
            default: begin
                if (eligible[0])      win_idx = 2'd0;
                else if (eligible[1]) win_idx = 2'd1;
                else                  win_idx = 2'd2;
            end
        endcase
    end

    always_comb begin
        state_next      = state;
        counter_next    = counter;
        gnt_next        = GNT;
        last_owner_next = last_owner;
`ifdef I2C_ARB_TIMEOUT_EN
        mask_next       = mask & REQ;
        flag_next       = TIMEOUT_FLAG & ~CLR_TIMEOUT;
        id_next         = TIMEOUT_ID;
`endif
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_next      = GRANT;
                    gnt_next        = 3'b001 << win_idx;
                    counter_next    = '0;
                    last_owner_next = win_idx;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_next   = GUARD;
                    gnt_next     = '0;
                    counter_next = '0;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (counter == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_next   = GUARD;
                    gnt_next     = '0;
                    counter_next = '0;
                    mask_next    = mask_next | GNT;
                    flag_next    = 1'b1;
                    id_next      = last_owner;
                end
`endif
                else begin
                    counter_next = counter + 32'd1;
                end
            end
            GUARD: begin
                if (counter == 32'(GUARD_CYCLES - 1)) begin
                    state_next   = IDLE;
                    counter_next = '0;
                end else begin
                    counter_next = counter + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            counter    <= '0;
            GNT        <= '0;
            last_owner <= 2'd2;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            GNT        <= gnt_next;
            last_owner <= last_owner_next;
            BUSY       <= (state_next != IDLE);
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // A timed-out requester stays masked until it drops REQ for a cycle
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mask         <= '0;
            TIMEOUT_FLAG <= 1'b0;
            TIMEOUT_ID   <= 2'd0;
        end else begin
            mask         <= mask_next;
            TIMEOUT_FLAG <= flag_next;
            TIMEOUT_ID   <= id_next;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed literal checks, then random traffic compared each cycle to a behavioural model.
// Honours I2C_ARB_TIMEOUT_EN the same way the design does.
module tb_i2c_bus_arbiter;

    localparam int GUARD   = 4;
    localparam int TIMEOUT = 20;

    logic       CLK_50 = 1'b0;
    logic       RESET_N = 1'b0;
    logic [2:0] REQ = '0;
    logic [2:0] SCL_IN = '1;
    logic [2:0] SDAO_IN = '1;
    logic       CLR_TIMEOUT = 1'b0;
    logic [2:0] GNT;
    logic       BUS_SCL, BUS_SDAO, BUSY, TIMEOUT_FLAG;
    logic [1:0] TIMEOUT_ID;

    int check_count = 0;
    int pass_count  = 0;
    bit cmp_en      = 1'b0;

    i2c_bus_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK_50(CLK_50), .RESET_N(RESET_N), .REQ(REQ), .SCL_IN(SCL_IN),
        .SDAO_IN(SDAO_IN), .CLR_TIMEOUT(CLR_TIMEOUT), .GNT(GNT),
        .BUS_SCL(BUS_SCL), .BUS_SDAO(BUS_SDAO), .BUSY(BUSY),
        .TIMEOUT_FLAG(TIMEOUT_FLAG), .TIMEOUT_ID(TIMEOUT_ID)
    );

    always #10 CLK_50 = ~CLK_50;

    // Model: who owns the bus, how long the guard gap still runs, how long the owner has held it
    typedef struct packed {
        logic        active;
        logic [1:0]  owner;
        logic [31:0] guard_left;
        logic [31:0] hold;
        logic [1:0]  last;
        logic [2:0]  mask;
        logic        flag;
        logic [1:0]  id;
    } model_t;

    localparam model_t MODEL_RESET = '{active: 1'b0, owner: 2'd0, guard_left: 32'd0, hold: 32'd0,
                                       last: 2'd2, mask: 3'b000, flag: 1'b0, id: 2'd0};

    model_t m = MODEL_RESET;

    function automatic model_t model_step(model_t cur, logic [2:0] req, logic clr);
        model_t nxt = cur;
        logic   found = 1'b0;
        logic   timed_out = 1'b0;
        logic [2:0] elig;
`ifdef I2C_ARB_TIMEOUT_EN
        nxt.mask = cur.mask & req;
`endif
        if (cur.active) begin
            if (!req[cur.owner]) begin
                nxt.active = 1'b0;
                nxt.guard_left = GUARD;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (cur.hold == TIMEOUT - 1) begin
                timed_out = 1'b1;
                nxt.active = 1'b0;
                nxt.guard_left = GUARD;
                nxt.mask[cur.owner] = 1'b1;
                nxt.id = cur.owner;
            end
`endif
            else begin
                nxt.hold = cur.hold + 1;
            end
        end else if (cur.guard_left != 0) begin
            nxt.guard_left = cur.guard_left - 1;
        end else begin
            elig = req & ~cur.mask;
            for (int k = 1; k <= 3; k++) begin
                int idx = (int'(cur.last) + k) % 3;
                if (!found && elig[idx]) begin
                    found = 1'b1;
                    nxt.active = 1'b1;
                    nxt.owner = 2'(idx);
                    nxt.last = 2'(idx);
                    nxt.hold = 0;
                end
            end
        end
`ifdef I2C_ARB_TIMEOUT_EN
        if (timed_out) nxt.flag = 1'b1;
        else if (clr) nxt.flag = 1'b0;
`endif
        return nxt;
    endfunction

    always @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) m <= MODEL_RESET;
        else          m <= model_step(m, REQ, CLR_TIMEOUT);
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    always @(negedge CLK_50) begin
        if (cmp_en) begin
            check_output("model_gnt", 32'(GNT), m.active ? 32'(3'b001 << m.owner) : 32'd0);
            check_output("model_busy", 32'(BUSY), 32'(m.active || m.guard_left != 0));
            check_output("model_scl", 32'(BUS_SCL), m.active ? 32'(SCL_IN[m.owner]) : 32'd1);
            check_output("model_sdao", 32'(BUS_SDAO), m.active ? 32'(SDAO_IN[m.owner]) : 32'd1);
            check_output("model_flag", 32'(TIMEOUT_FLAG), 32'(m.flag));
            check_output("model_id", 32'(TIMEOUT_ID), 32'(m.id));
        end
    end

    task automatic next_cycle();
        @(posedge CLK_50);
        #2;
    endtask

    task automatic apply_stimulus(input logic [2:0] req, input logic [2:0] scl, input logic [2:0] sdao, input logic clr);
        REQ = req;
        SCL_IN = scl;
        SDAO_IN = sdao;
        CLR_TIMEOUT = clr;
        #1;
    endtask

    initial begin
        logic [2:0] req_r;
        repeat (3) @(posedge CLK_50);
        cmp_en = 1'b1;
        next_cycle();
        RESET_N = 1'b1;
        #1;
        check_output("rst_gnt", 32'(GNT), 32'd0);
        check_output("rst_busy", 32'(BUSY), 32'd0);
        check_output("rst_scl", 32'(BUS_SCL), 32'd1);
        check_output("rst_sdao", 32'(BUS_SDAO), 32'd1);
        check_output("rst_flag", 32'(TIMEOUT_FLAG), 32'd0);
        check_output("rst_id", 32'(TIMEOUT_ID), 32'd0);

        // Single requester: grant latency, bus follows owner, guard length
        next_cycle();
        apply_stimulus(3'b001, 3'b110, 3'b111, 1'b0);
        next_cycle();
        check_output("grant0", 32'(GNT), 32'd1);
        check_output("bus0_scl", 32'(BUS_SCL), 32'd0);
        check_output("bus0_sdao", 32'(BUS_SDAO), 32'd1);
        apply_stimulus(3'b000, 3'b111, 3'b110, 1'b0);
        check_output("bus0_scl_b", 32'(BUS_SCL), 32'd1);
        check_output("bus0_sdao_b", 32'(BUS_SDAO), 32'd0);
        next_cycle();
        check_output("release_gnt", 32'(GNT), 32'd0);
        check_output("guard_busy", 32'(BUSY), 32'd1);
        repeat (3) next_cycle();
        check_output("guard_busy_end", 32'(BUSY), 32'd1);
        next_cycle();
        check_output("idle_busy", 32'(BUSY), 32'd0);

        // Non-owner lines must not reach the bus
        apply_stimulus(3'b010, 3'b101, 3'b101, 1'b0);
        next_cycle();
        check_output("grant1", 32'(GNT), 32'd2);
        check_output("bus1_scl", 32'(BUS_SCL), 32'd0);
        check_output("bus1_sdao", 32'(BUS_SDAO), 32'd0);
        apply_stimulus(3'b010, 3'b010, 3'b010, 1'b0);
        check_output("bus1_scl_b", 32'(BUS_SCL), 32'd1);
        check_output("bus1_sdao_b", 32'(BUS_SDAO), 32'd1);

        // Asynchronous reset mid-grant releases the bus without a clock
        apply_stimulus(3'b010, 3'b000, 3'b000, 1'b0);
        check_output("pre_rst_scl", 32'(BUS_SCL), 32'd0);
        RESET_N = 1'b0;
        #1;
        check_output("async_gnt", 32'(GNT), 32'd0);
        check_output("async_scl", 32'(BUS_SCL), 32'd1);
        check_output("async_sdao", 32'(BUS_SDAO), 32'd1);
        check_output("async_busy", 32'(BUSY), 32'd0);
        next_cycle();
        RESET_N = 1'b1;
        apply_stimulus(3'b100, 3'b111, 3'b111, 1'b0);
        next_cycle();
        check_output("post_rst_grant2", 32'(GNT), 32'd4);
        apply_stimulus(3'b000, 3'b111, 3'b111, 1'b0);
        repeat (6) next_cycle();

        // Long hold by requester 0
        apply_stimulus(3'b001, 3'b111, 3'b111, 1'b0);
        next_cycle();
        repeat (25) next_cycle();
`ifdef I2C_ARB_TIMEOUT_EN
        check_output("to_gnt", 32'(GNT), 32'd0);
        check_output("to_flag", 32'(TIMEOUT_FLAG), 32'd1);
        check_output("to_id", 32'(TIMEOUT_ID), 32'd0);
        apply_stimulus(3'b011, 3'b111, 3'b111, 1'b0);
        next_cycle();
        check_output("to_regrant", 32'(GNT), 32'd2);
`else
        check_output("hold_gnt", 32'(GNT), 32'd1);
        check_output("hold_flag", 32'(TIMEOUT_FLAG), 32'd0);
        apply_stimulus(3'b011, 3'b111, 3'b111, 1'b0);
        next_cycle();
        check_output("hold_gnt_b", 32'(GNT), 32'd1);
`endif
        apply_stimulus(3'b011, 3'b111, 3'b111, 1'b1);
        next_cycle();
        apply_stimulus(3'b011, 3'b111, 3'b111, 1'b0);
        check_output("clr_flag", 32'(TIMEOUT_FLAG), 32'd0);

        // Random traffic: sticky requests, random bus lines, occasional clear and reset
        req_r = 3'b011;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            next_cycle();
            if (!RESET_N) RESET_N = 1'b1;
            else if ($urandom_range(0, 399) == 0) RESET_N = 1'b0;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 11) == 0) req_r[b] = ~req_r[b];
            apply_stimulus(req_r, 3'($urandom), 3'($urandom), $urandom_range(0, 30) == 0);
        end
        RESET_N = 1'b1;
        repeat (2) next_cycle();
        cmp_en = 1'b0;

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 125, idle guard time in CLK_50 cycles between bus owners (2.5 us).
REQ-002 Parameter TIMEOUT_CYCLES, default 5000000, maximum grant hold in CLK_50 cycles (100 ms).
REQ-003 Port CLK_50  input  1  system clock, 50 MHz, all state on rising edge.
REQ-004 Port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 Port REQ  input  3  per-requester bus request, level; bit0 = HDC1000 controller, bit1 = accelerometer, bit2 = light sensor.
REQ-006 Port SCL_IN  input  3  per-requester SCL drive (1 = release).
REQ-007 Port SDAO_IN  input  3  per-requester SDA drive (1 = release).
REQ-008 Port CLR_TIMEOUT  input  1  single-cycle pulse clearing TIMEOUT_FLAG.
REQ-009 Port GNT  output  3  one-hot grant, registered.
REQ-010 Port BUS_SCL  output  1  muxed SCL to open-drain pad (1 = release).
REQ-011 Port BUS_SDAO  output  1  muxed SDA drive to open-drain pad (1 = release).
REQ-012 Port BUSY  output  1  high in GRANT or GUARD state.
REQ-013 Port TIMEOUT_FLAG  output  1  sticky timeout indicator.
REQ-014 Port TIMEOUT_ID  output  2  index of requester that last timed out.

Function
REQ-015 FSM states IDLE, GRANT, GUARD; one 32-bit counter shared by GRANT and GUARD.
REQ-016 IDLE: if any eligible REQ bit high, select winner, set GNT one-hot on the next edge, clear counter, enter GRANT; latency REQ->GNT exactly 1 cycle.
REQ-017 Winner: round-robin, search starts at index (last owner+1) mod 3; after reset last owner = 2 so bit0 has first priority.
REQ-018 GRANT: counter increments each cycle; when REQ[owner] low, GNT<=0, counter<=0, enter GUARD on that edge.
REQ-019 GUARD: GNT=0, BUS_SCL=BUS_SDAO=1; after GUARD_CYCLES cycles enter IDLE; requests seen during GUARD wait.
REQ-020 BUS_SCL = SCL_IN[owner] and BUS_SDAO = SDAO_IN[owner] while GNT[owner]=1; otherwise both 1; non-granted inputs never reach the bus.
REQ-021 GNT never has more than one bit set; GNT change only via GUARD, never owner-to-owner directly.
REQ-022 REQ dropping and rising again in the same GRANT owner is treated as release; the new request re-arbitrates after GUARD.
REQ-023 CLR_TIMEOUT coincident with a new timeout: set wins.
REQ-024 BUSY = (state != IDLE), registered.

Reset
REQ-025 RESET_N low: state IDLE, GNT=000, counter 0, last owner 2, TIMEOUT_FLAG 0, TIMEOUT_ID 0, mask 000, BUSY 0, BUS_SCL=BUS_SDAO=1.
REQ-026 Reset mid-transfer releases the bus immediately (asynchronous), no guard period.

Configuration
REQ-027 Macro I2C_ARB_TIMEOUT_EN defined: in GRANT, when counter reaches TIMEOUT_CYCLES-1 with REQ[owner] still high, GNT<=0, TIMEOUT_FLAG<=1, TIMEOUT_ID<=owner, mask[owner]<=1, enter GUARD.
REQ-028 Masked requester is ineligible until its REQ has been low for at least one cycle, which clears its mask bit.
REQ-029 Macro undefined: no timeout, mask logic absent, TIMEOUT_FLAG and TIMEOUT_ID tied 0, grant held until REQ drops.

Verification (GUARD_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-030 REQ=001 from IDLE -> GNT=001 next cycle; BUS_SCL follows SCL_IN[0]; REQ=000 -> GNT=000 next cycle, BUSY high 4 more cycles.
REQ-031 REQ=111 held, each owner drops REQ after 5 cycles then reasserts -> grant order 001,010,100,001 with 4-cycle gaps.
REQ-032 GNT=010 while SCL_IN=101, SDAO_IN=101 -> BUS_SCL=0, BUS_SDAO=0; SCL_IN=010, SDAO_IN=010 -> both 1.
REQ-033 With I2C_ARB_TIMEOUT_EN, REQ=001 held 30 cycles -> GNT drops after 20 cycles, TIMEOUT_FLAG=1, TIMEOUT_ID=0, no regrant until REQ[0] low 1 cycle; REQ=011 then -> GNT=010.
REQ-034 RESET_N low during GRANT -> GNT=000, BUS_SCL=BUS_SDAO=1 without waiting for clock; after release REQ=100 -> GNT=100 one cycle later.
REQ-035 Without I2C_ARB_TIMEOUT_EN, REQ=001 held 100 cycles -> GNT=001 throughout, TIMEOUT_FLAG=0.
